// File: rtl/periph_input_capture.sv
// periph_input_capture
// Memory-mapped input peripheral. Board switches and push-buttons are
// synchronised and debounced. Button presses are latched as sticky events.
// The CPU reads the switch, button, event and interrupt-enable registers
// through a four-word window, and the peripheral raises a level interrupt
// while any enabled event is pending.

module periph_input_capture #(
  parameter int N_SW    = 8,
  parameter int N_BTN   = 4,
  parameter int DEB_CYC = 1_000_000,
  parameter int DEB_W   = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_SW-1:0]  sw_raw,
  input  logic [N_BTN-1:0] btn_raw,
  input  logic [1:0]       addr,
  input  logic             wr_en,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata,
  output logic             irq
);

  // Switches occupy the low bits of the combined input vector; buttons sit above them.
  localparam int NT = N_SW + N_BTN;
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYC - 1);

  logic [NT-1:0]    w_raw;
  logic [NT-1:0]    r_sync1;
  logic [NT-1:0]    r_sync2;
  logic [NT-1:0]    r_stable;
  logic [NT-1:0]    w_accept;
  logic [DEB_W-1:0] r_cnt [NT];

  logic [N_SW-1:0]  w_swStable;
  logic [N_BTN-1:0] w_btnStable;
  logic [N_BTN-1:0] w_press;
  logic [N_BTN-1:0] w_clrMask;
  logic [N_BTN-1:0] r_edgeFlags;
  logic [N_BTN-1:0] r_irqEn;
  logic             w_edgeWr;
  logic             w_irqEnWr;
  logic             w_unused;

  assign w_raw = {btn_raw, sw_raw};

  // The raw pins are asynchronous to clk, so each bit passes through two flops before any logic uses it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
    end
  end

  // A bit is accepted on the cycle its counter reaches the last count while the synced level still differs.
  always_comb begin
    w_accept = '0;
    for (int i = 0; i < NT; i++) begin
      w_accept[i] = (r_sync2[i] != r_stable[i]) && (r_cnt[i] == DEB_LAST);
    end
  end

  // Each bit has its own debouncer. Returning to the stable level restarts the count, and the counter clears on acceptance, so it never saturates.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stable <= '0;
      for (int i = 0; i < NT; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NT; i++) begin
        if (r_sync2[i] == r_stable[i]) begin
          r_cnt[i] <= '0;
        end else if (w_accept[i]) begin
          r_stable[i] <= r_sync2[i];
          r_cnt[i]    <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign w_swStable  = r_stable[N_SW-1:0];
  assign w_btnStable = r_stable[NT-1:N_SW];

  // A press is the cycle a button's stable level is about to go from 0 to 1. Releases produce no event.
  assign w_press = w_accept[NT-1:N_SW] & r_sync2[NT-1:N_SW];

  assign w_edgeWr  = wr_en && (addr == 2'd2);
  assign w_irqEnWr = wr_en && (addr == 2'd3);
  assign w_clrMask = w_edgeWr ? wdata[N_BTN-1:0] : '0;

  // Event flags are sticky and cleared by writing 1. A press in the same cycle as its clear wins, so no event is lost.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_edgeFlags <= '0;
    end else begin
      r_edgeFlags <= (r_edgeFlags & ~w_clrMask) | w_press;
    end
  end

  // The interrupt-enable mask is an ordinary read/write register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_irqEn <= '0;
    end else if (w_irqEnWr) begin
      r_irqEn <= wdata[N_BTN-1:0];
    end
  end

  // The read mux is combinational from addr, and unused upper bits read as zero.
  always_comb begin
    rdata = '0;
    case (addr)
      2'd0:    rdata[N_SW-1:0]  = w_swStable;
      2'd1:    rdata[N_BTN-1:0] = w_btnStable;
      2'd2:    rdata[N_BTN-1:0] = r_edgeFlags;
      2'd3:    rdata[N_BTN-1:0] = r_irqEn;
      default: rdata = '0;
    endcase
  end

  assign irq = |(r_edgeFlags & r_irqEn);

  // Upper write-data bits have no storage behind them.
  assign w_unused = ^wdata;

endmodule
